// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the decode/execute hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_ADD_W = 5;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_RAW = 2'd1,
    ST_MUL = 2'd2
  } hctrl_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_OR  = 2'd1,
    ALU_MUL = 2'd2,
    ALU_ST  = 2'd3
  } alu_op_e;

  // A writer hits when it writes a register that a used source reads; r0 is not special.
  function automatic logic src_hit(
    input logic [REG_ADD_W-1:0] rs1_add,
    input logic                 rs1_use,
    input logic [REG_ADD_W-1:0] rs2_add,
    input logic                 rs2_use,
    input logic [REG_ADD_W-1:0] dest,
    input logic                 wr_en
  );
    return wr_en & ((rs1_use & (rs1_add == dest)) | (rs2_use & (rs2_add == dest)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage destinations in, stall controls out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic                 dec_hctrl_vld;
  logic [REG_ADD_W-1:0] dec_hctrl_rs1_add;
  logic                 dec_hctrl_rs1_use;
  logic [REG_ADD_W-1:0] dec_hctrl_rs2_add;
  logic                 dec_hctrl_rs2_use;
  logic                 exe_hctrl_vld;
  logic [1:0]           exe_hctrl_alu_ctrl;
  logic [REG_ADD_W-1:0] exe_hctrl_reg_wr_add_st;
  logic                 exe_hctrl_reg_wr_en;
  logic [REG_ADD_W-1:0] mem_hctrl_reg_wr_add;
  logic                 mem_hctrl_reg_wr_en;
  logic [REG_ADD_W-1:0] wb_hctrl_reg_wr_add;
  logic                 wb_hctrl_reg_wr_en;
  logic                 hctrl_pc_stall;
  logic                 hctrl_dec_stall;
  logic                 hctrl_exe_bubble;
  logic                 hctrl_exe_hold;

  modport master (
    output dec_hctrl_vld, dec_hctrl_rs1_add, dec_hctrl_rs1_use,
           dec_hctrl_rs2_add, dec_hctrl_rs2_use,
           exe_hctrl_vld, exe_hctrl_alu_ctrl, exe_hctrl_reg_wr_add_st, exe_hctrl_reg_wr_en,
           mem_hctrl_reg_wr_add, mem_hctrl_reg_wr_en,
           wb_hctrl_reg_wr_add, wb_hctrl_reg_wr_en,
    input  hctrl_pc_stall, hctrl_dec_stall, hctrl_exe_bubble, hctrl_exe_hold
  );

  modport slave (
    input  dec_hctrl_vld, dec_hctrl_rs1_add, dec_hctrl_rs1_use,
           dec_hctrl_rs2_add, dec_hctrl_rs2_use,
           exe_hctrl_vld, exe_hctrl_alu_ctrl, exe_hctrl_reg_wr_add_st, exe_hctrl_reg_wr_en,
           mem_hctrl_reg_wr_add, mem_hctrl_reg_wr_en,
           wb_hctrl_reg_wr_add, wb_hctrl_reg_wr_en,
    output hctrl_pc_stall, hctrl_dec_stall, hctrl_exe_bubble, hctrl_exe_hold
  );

endinterface

// File: rtl/hazard_ctrl_sat_cnt.sv
// Saturating up-counter with increment enable, used for stall statistics.
module hctrl_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the decode/execute boundary: RAW bubbles and mul hold.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYC  = 3,
  parameter int unsigned EXE_DIST = 3,
  parameter int unsigned MEM_DIST = 2,
  parameter int unsigned WB_DIST  = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hif,
  output logic [1:0]       hctrl_state,
  output logic [CNT_W-1:0] hctrl_raw_cnt,
  output logic [CNT_W-1:0] hctrl_mul_cnt
);

  localparam logic [3:0] EXE_D = 4'(EXE_DIST);
  localparam logic [3:0] MEM_D = 4'(MEM_DIST);
  localparam logic [3:0] WB_D  = 4'(WB_DIST);
  localparam logic [3:0] MUL_M = 4'(MUL_CYC - 1);

  hctrl_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         exe_hit, mem_hit, wb_hit;
  logic [3:0]   d_len, m_len;
  logic         bubble, hold;

  assign exe_hit = hif.dec_hctrl_vld &
                   src_hit(hif.dec_hctrl_rs1_add, hif.dec_hctrl_rs1_use,
                           hif.dec_hctrl_rs2_add, hif.dec_hctrl_rs2_use,
                           hif.exe_hctrl_reg_wr_add_st, hif.exe_hctrl_reg_wr_en);
  assign mem_hit = hif.dec_hctrl_vld &
                   src_hit(hif.dec_hctrl_rs1_add, hif.dec_hctrl_rs1_use,
                           hif.dec_hctrl_rs2_add, hif.dec_hctrl_rs2_use,
                           hif.mem_hctrl_reg_wr_add, hif.mem_hctrl_reg_wr_en);
  assign wb_hit  = hif.dec_hctrl_vld &
                   src_hit(hif.dec_hctrl_rs1_add, hif.dec_hctrl_rs1_use,
                           hif.dec_hctrl_rs2_add, hif.dec_hctrl_rs2_use,
                           hif.wb_hctrl_reg_wr_add, hif.wb_hctrl_reg_wr_en);

  // Stages with a zero distance are skipped so an older writer can still set the length.
  always_comb begin
    d_len = '0;
    if (exe_hit && (EXE_D != 4'd0)) begin
      d_len = EXE_D;
    end else if (mem_hit && (MEM_D != 4'd0)) begin
      d_len = MEM_D;
    end else if (wb_hit && (WB_D != 4'd0)) begin
      d_len = WB_D;
    end
  end

  always_comb begin
    m_len = '0;
    if (hif.exe_hctrl_vld && (hif.exe_hctrl_alu_ctrl == ALU_MUL)) begin
      m_len = MUL_M;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The RUN cycle is the first stall cycle, so the countdown loads length-2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;
    hold    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (m_len != 4'd0) begin
          hold = 1'b1;
          if (m_len > 4'd1) begin
            state_d = ST_MUL;
            cnt_d   = m_len - 4'd2;
          end
        end else if (d_len != 4'd0) begin
          bubble = 1'b1;
          if (d_len > 4'd1) begin
            state_d = ST_RAW;
            cnt_d   = d_len - 4'd2;
          end
        end
      end
      ST_MUL: begin
        hold = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RAW: begin
        bubble = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset masks the Mealy RUN outputs as well as the registered state.
  assign hif.hctrl_exe_bubble = bubble & rst;
  assign hif.hctrl_exe_hold   = hold & rst;
  assign hif.hctrl_dec_stall  = (bubble | hold) & rst;
  assign hif.hctrl_pc_stall   = (bubble | hold) & rst;
  assign hctrl_state          = state_q;

  hctrl_sat_cnt #(.W(CNT_W)) u_raw_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hif.hctrl_exe_bubble),
    .cnt (hctrl_raw_cnt)
  );

  hctrl_sat_cnt #(.W(CNT_W)) u_mul_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hif.hctrl_exe_hold),
    .cnt (hctrl_mul_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a MUL_CYC=1, CNT_W=2 instance.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  hazard_ctrl_if if0();
  hazard_ctrl_if if1();

  logic [1:0]  st0, st1;
  logic [15:0] raw0, mul0;
  logic [1:0]  raw1, mul1;

  always #5 clk = ~clk;

  // Second instance sees exactly the same pipeline stimulus.
  assign if1.dec_hctrl_vld           = if0.dec_hctrl_vld;
  assign if1.dec_hctrl_rs1_add       = if0.dec_hctrl_rs1_add;
  assign if1.dec_hctrl_rs1_use       = if0.dec_hctrl_rs1_use;
  assign if1.dec_hctrl_rs2_add       = if0.dec_hctrl_rs2_add;
  assign if1.dec_hctrl_rs2_use       = if0.dec_hctrl_rs2_use;
  assign if1.exe_hctrl_vld           = if0.exe_hctrl_vld;
  assign if1.exe_hctrl_alu_ctrl      = if0.exe_hctrl_alu_ctrl;
  assign if1.exe_hctrl_reg_wr_add_st = if0.exe_hctrl_reg_wr_add_st;
  assign if1.exe_hctrl_reg_wr_en     = if0.exe_hctrl_reg_wr_en;
  assign if1.mem_hctrl_reg_wr_add    = if0.mem_hctrl_reg_wr_add;
  assign if1.mem_hctrl_reg_wr_en     = if0.mem_hctrl_reg_wr_en;
  assign if1.wb_hctrl_reg_wr_add     = if0.wb_hctrl_reg_wr_add;
  assign if1.wb_hctrl_reg_wr_en      = if0.wb_hctrl_reg_wr_en;

  hazard_ctrl #(
    .MUL_CYC (3), .EXE_DIST (3), .MEM_DIST (2), .WB_DIST (1), .CNT_W (16)
  ) u_dut0 (
    .clk (clk), .rst (rst), .hif (if0),
    .hctrl_state (st0), .hctrl_raw_cnt (raw0), .hctrl_mul_cnt (mul0)
  );

  hazard_ctrl #(
    .MUL_CYC (1), .EXE_DIST (3), .MEM_DIST (2), .WB_DIST (1), .CNT_W (2)
  ) u_dut1 (
    .clk (clk), .rst (rst), .hif (if1),
    .hctrl_state (st1), .hctrl_raw_cnt (raw1), .hctrl_mul_cnt (mul1)
  );

  function automatic logic [5:0] obs0();
    return {if0.hctrl_exe_bubble, if0.hctrl_exe_hold, if0.hctrl_dec_stall,
            if0.hctrl_pc_stall, st0};
  endfunction

  function automatic logic [5:0] obs1();
    return {if1.hctrl_exe_bubble, if1.hctrl_exe_hold, if1.hctrl_dec_stall,
            if1.hctrl_pc_stall, st1};
  endfunction

  // Expected {bubble, hold, dec_stall, pc_stall, state}.
  function automatic logic [5:0] mk(input logic b, input logic h, input logic [1:0] s);
    return {b, h, b | h, b | h, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    if0.dec_hctrl_vld           = 1'b0;
    if0.dec_hctrl_rs1_add       = '0;
    if0.dec_hctrl_rs1_use       = 1'b0;
    if0.dec_hctrl_rs2_add       = '0;
    if0.dec_hctrl_rs2_use       = 1'b0;
    if0.exe_hctrl_vld           = 1'b0;
    if0.exe_hctrl_alu_ctrl      = ALU_ADD;
    if0.exe_hctrl_reg_wr_add_st = '0;
    if0.exe_hctrl_reg_wr_en     = 1'b0;
    if0.mem_hctrl_reg_wr_add    = '0;
    if0.mem_hctrl_reg_wr_en     = 1'b0;
    if0.wb_hctrl_reg_wr_add     = '0;
    if0.wb_hctrl_reg_wr_en      = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic set_exe(input logic [4:0] a, input logic [1:0] op);
    if0.exe_hctrl_vld = 1'b1; if0.exe_hctrl_alu_ctrl = op;
    if0.exe_hctrl_reg_wr_add_st = a; if0.exe_hctrl_reg_wr_en = 1'b1;
  endtask

  task automatic set_rs1(input logic [4:0] a);
    if0.dec_hctrl_vld = 1'b1; if0.dec_hctrl_rs1_add = a; if0.dec_hctrl_rs1_use = 1'b1;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b0;
    set_exe(5'd5, ALU_MUL);
    set_rs1(5'd5);
    #1;
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN)) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want %b", obs0(), mk(0, 0, ST_RUN));
    end
    tests_run++;
    if ({raw0, mul0} !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: got raw=%0d mul=%0d want 0 0", raw0, mul0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs0() !== mk(0, 1, ST_RUN)) begin
      tests_failed++;
      $display("FAIL reset_release_stall: got %b want %b", obs0(), mk(0, 1, ST_RUN));
    end
    tick();
    clr();
    #1;
    tests_run++;
    if (obs0() !== mk(0, 1, ST_MUL)) begin
      tests_failed++;
      $display("FAIL reset_mul_hold2: got %b want %b", obs0(), mk(0, 1, ST_MUL));
    end
    tick();
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN) || mul0 !== 16'd2 || raw0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mul_end: got %b mul=%0d raw=%0d want %b mul=2 raw=0",
               obs0(), mul0, raw0, mk(0, 0, ST_RUN));
    end
  endtask

  task automatic test_raw_exe();
    logic [5:0] ex [4];
    ex = '{mk(1, 0, ST_RUN), mk(1, 0, ST_RAW), mk(1, 0, ST_RAW), mk(0, 0, ST_RUN)};
    do_reset();
    set_exe(5'd5, ALU_ADD);
    set_rs1(5'd5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        clr();
      end
      #1;
      tests_run++;
      if (obs0() !== ex[i]) begin
        tests_failed++;
        $display("FAIL raw_exe cyc%0d: got %b want %b", i, obs0(), ex[i]);
      end
    end
    tests_run++;
    if (raw0 !== 16'd3 || mul0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL raw_exe_cnt: got raw=%0d mul=%0d want 3 0", raw0, mul0);
    end
  endtask

  task automatic test_priority();
    logic [5:0] ex [4];
    ex = '{mk(1, 0, ST_RUN), mk(1, 0, ST_RAW), mk(1, 0, ST_RAW), mk(0, 0, ST_RUN)};
    do_reset();
    set_exe(5'd5, ALU_OR);
    set_rs1(5'd5);
    if0.mem_hctrl_reg_wr_add = 5'd5; if0.mem_hctrl_reg_wr_en = 1'b1;
    if0.wb_hctrl_reg_wr_add  = 5'd7; if0.wb_hctrl_reg_wr_en  = 1'b1;
    if0.dec_hctrl_rs2_add = 5'd7; if0.dec_hctrl_rs2_use = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        clr();
      end
      #1;
      tests_run++;
      if (obs0() !== ex[i]) begin
        tests_failed++;
        $display("FAIL prio_exe cyc%0d: got %b want %b", i, obs0(), ex[i]);
      end
    end
    ex = '{mk(1, 0, ST_RUN), mk(1, 0, ST_RAW), mk(0, 0, ST_RUN), mk(0, 0, ST_RUN)};
    if0.mem_hctrl_reg_wr_add = 5'd6; if0.mem_hctrl_reg_wr_en = 1'b1;
    set_rs1(5'd6);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        clr();
      end
      #1;
      tests_run++;
      if (obs0() !== ex[i]) begin
        tests_failed++;
        $display("FAIL prio_mem cyc%0d: got %b want %b", i, obs0(), ex[i]);
      end
    end
    if0.wb_hctrl_reg_wr_add = 5'd9; if0.wb_hctrl_reg_wr_en = 1'b1;
    if0.dec_hctrl_vld = 1'b1; if0.dec_hctrl_rs2_add = 5'd9; if0.dec_hctrl_rs2_use = 1'b1;
    #1;
    tests_run++;
    if (obs0() !== mk(1, 0, ST_RUN)) begin
      tests_failed++;
      $display("FAIL prio_wb_c0: got %b want %b", obs0(), mk(1, 0, ST_RUN));
    end
    tick();
    clr();
    #1;
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN) || raw0 !== 16'd6) begin
      tests_failed++;
      $display("FAIL prio_wb_c1: got %b raw=%0d want %b raw=6", obs0(), raw0, mk(0, 0, ST_RUN));
    end
  endtask

  task automatic test_mul_raw();
    logic [5:0] ex [6];
    ex = '{mk(0, 1, ST_RUN), mk(0, 1, ST_MUL), mk(1, 0, ST_RUN),
           mk(1, 0, ST_RAW), mk(1, 0, ST_RAW), mk(0, 0, ST_RUN)};
    do_reset();
    set_exe(5'd12, ALU_MUL);
    set_rs1(5'd12);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      // Last exe cycle of the mul: still writing r12 but no longer requesting a hold.
      if (i == 2) if0.exe_hctrl_alu_ctrl = ALU_ADD;
      if (i == 3) clr();
      #1;
      tests_run++;
      if (obs0() !== ex[i]) begin
        tests_failed++;
        $display("FAIL mul_raw cyc%0d: got %b want %b", i, obs0(), ex[i]);
      end
    end
    tests_run++;
    if (mul0 !== 16'd2 || raw0 !== 16'd3) begin
      tests_failed++;
      $display("FAIL mul_raw_cnt: got mul=%0d raw=%0d want 2 3", mul0, raw0);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    set_exe(5'd5, ALU_ADD);
    if0.dec_hctrl_vld = 1'b1;
    if0.dec_hctrl_rs1_add = 5'd5; if0.dec_hctrl_rs2_add = 5'd5;
    #1;
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN)) begin
      tests_failed++;
      $display("FAIL nostall_use0: got %b want %b", obs0(), mk(0, 0, ST_RUN));
    end
    if0.dec_hctrl_rs1_use = 1'b1;
    if0.exe_hctrl_reg_wr_en = 1'b0;
    #1;
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN)) begin
      tests_failed++;
      $display("FAIL nostall_wren0: got %b want %b", obs0(), mk(0, 0, ST_RUN));
    end
    if0.exe_hctrl_reg_wr_en = 1'b1;
    if0.dec_hctrl_vld = 1'b0;
    #1;
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN)) begin
      tests_failed++;
      $display("FAIL nostall_vld0: got %b want %b", obs0(), mk(0, 0, ST_RUN));
    end
    tick();
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN) || raw0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL nostall_after: got %b raw=%0d want %b raw=0", obs0(), raw0, mk(0, 0, ST_RUN));
    end
    clr();
    set_exe(5'd0, ALU_ADD);
    set_rs1(5'd0);
    #1;
    tests_run++;
    if (obs0() !== mk(1, 0, ST_RUN)) begin
      tests_failed++;
      $display("FAIL r0_match: got %b want %b", obs0(), mk(1, 0, ST_RUN));
    end
    do_reset();
    set_exe(5'd3, ALU_MUL);
    if0.exe_hctrl_reg_wr_en = 1'b0;
    #1;
    tests_run++;
    if (obs1() !== mk(0, 0, ST_RUN) || obs0() !== mk(0, 1, ST_RUN)) begin
      tests_failed++;
      $display("FAIL mulcyc1_nohold: got dut1=%b dut0=%b want %b %b",
               obs1(), obs0(), mk(0, 0, ST_RUN), mk(0, 1, ST_RUN));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_exe(5'd8, ALU_ADD);
    set_rs1(5'd8);
    tick();
    clr();
    #1;
    tests_run++;
    if (obs0() !== mk(1, 0, ST_RAW)) begin
      tests_failed++;
      $display("FAIL midrst_pre: got %b want %b", obs0(), mk(1, 0, ST_RAW));
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN) || raw0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_abort: got %b raw=%0d want %b raw=0", obs0(), raw0, mk(0, 0, ST_RUN));
    end
    tick();
    rst = 1'b1;
    #1;
    tick();
    tests_run++;
    if (obs0() !== mk(0, 0, ST_RUN) || raw0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_after: got %b raw=%0d want %b raw=0", obs0(), raw0, mk(0, 0, ST_RUN));
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_exe(5'd4, ALU_ADD);
    set_rs1(5'd4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      tests_run++;
      if (if1.hctrl_exe_bubble !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat_bubble cyc%0d: got %b want 1", i, if1.hctrl_exe_bubble);
      end
    end
    tick();
    clr();
    tests_run++;
    if (raw1 !== 2'd3 || raw0 !== 16'd5) begin
      tests_failed++;
      $display("FAIL sat_cnt: got raw1=%0d raw0=%0d want 3 5", raw1, raw0);
    end
    do_reset();
  endtask

  initial begin
    clr();
    test_reset();
    test_raw_exe();
    test_priority();
    test_mul_raw();
    test_no_stall();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
